// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg
//   Shared definitions for the bit-serial add/subtract controller:
//   FSM state encodings and the default operand width.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        DONE_ST = 2'b10
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// FULL_ADDER
//   Existing 1-bit full adder cell, time-shared by serial_adder_ctrl.
//   Ports:
//     A, B  : input operand bits
//     CI    : carry in
//     S     : sum bit
//     CO    : carry out
module FULL_ADDER (
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic S,
    output logic CO
);

    assign S  = A ^ B ^ CI;
    assign CO = (A & B) | (CI & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial add/subtract controller. One FULL_ADDER cell is reused over
//   WIDTH cycles, LSB first, to produce a WIDTH-bit result with carry,
//   signed-overflow and zero flags.
//   Ports:
//     CLK       : rising-edge clock
//     RST       : asynchronous reset, active low
//     START     : request, sampled only in IDLE or DONE_ST
//     SnA       : 0 = A+B, 1 = A-B (latched with START)
//     A, B      : operands (latched with START)
//     R         : registered result, held until the next completion
//     CO        : final carry out (for subtract, 1 = no borrow)
//     OVF       : signed overflow
//     ZERO      : R == 0
//     BUSY      : high while in RUN
//     DONE      : one-cycle pulse, R and flags valid from this cycle
//     dbgState  : current FSM state
//
//   Handshake: START is a level sampled on the rising edge while the
//   controller is in IDLE or DONE_ST; that edge is the accept edge and
//   latches A/B/SnA. START is ignored while BUSY. DONE pulses for exactly one
//   cycle WIDTH edges after the accept edge; keeping START high during that
//   cycle starts the next operation back-to-back on the following edge.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SnA,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] R,
    output logic             CO,
    output logic             OVF,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE,
    output state_t           dbgState
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           stateNext;
    logic             accept;
    logic             lastBit;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] resSh;
    logic [WIDTH-1:0] resNext;
    logic [CNT_W-1:0] bitCnt;
    logic             carry;
    logic             faSum;
    logic             faCo;

    FULL_ADDER uFullAdder (
        .A  (sa[0]),
        .B  (sb[0]),
        .CI (carry),
        .S  (faSum),
        .CO (faCo)
    );

    // Result shift register as it will look after this edge's bit lands.
    assign resNext = {faSum, resSh[WIDTH-1:1]};
    assign lastBit = (state == RUN) && (bitCnt == LAST_BIT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    accept    = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (lastBit) begin
                    stateNext = DONE_ST;
                end
            end
            DONE_ST: begin
                if (START) begin
                    accept    = 1'b1;
                    stateNext = RUN;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sa     <= '0;
            sb     <= '0;
            resSh  <= '0;
            bitCnt <= '0;
            carry  <= 1'b0;
            R      <= '0;
            CO     <= 1'b0;
            OVF    <= 1'b0;
            ZERO   <= 1'b0;
        end else if (accept) begin
            // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
            sa     <= A;
            sb     <= SnA ? ~B : B;
            carry  <= SnA;
            bitCnt <= '0;
        end else if (state == RUN) begin
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            resSh  <= resNext;
            carry  <= faCo;
            bitCnt <= bitCnt + CNT_W'(1);
            if (lastBit) begin
                R    <= resNext;
                CO   <= faCo;
                // carry still holds the carry into the MSB on this edge.
                OVF  <= carry ^ faCo;
                ZERO <= (resNext == '0);
            end
        end
    end

    assign BUSY     = (state == RUN);
    assign DONE     = (state == DONE_ST);
    assign dbgState = state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
    import serial_adder_ctrl_pkg::*;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          START;
    logic          SnA;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [W-1:0]  R;
    logic          CO;
    logic          OVF;
    logic          ZERO;
    logic          BUSY;
    logic          DONE;
    state_t        dbgState;

    // Scoreboard entries: {R, CO, OVF, ZERO}
    logic [W+2:0]  exp_q[$];
    int            checks;
    int            errors;
    int            overlap_cnt;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .CLK      (clk),
        .RST      (rst_n),
        .START    (START),
        .SnA      (SnA),
        .A        (A),
        .B        (B),
        .R        (R),
        .CO       (CO),
        .OVF      (OVF),
        .ZERO     (ZERO),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .dbgState (dbgState)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written with plain integer add/subtract.
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        logic [W:0]   full;
        logic [W-1:0] res;
        logic         co;
        logic         ovf;
        if (s) begin
            full = {1'b0, a} - {1'b0, b};
            res  = full[W-1:0];
            co   = ~full[W];
            ovf  = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            res  = full[W-1:0];
            co   = full[W];
            ovf  = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
        end
        return {res, co, ovf, (res == '0)};
    endfunction

    // driver: present an operation and release START after the accept edge
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                            input bit track, input logic [W+2:0] exp_v);
        @(negedge clk);
        A     = a;
        B     = b;
        SnA   = s;
        START = 1'b1;
        if (track) exp_q.push_back(exp_v);
        @(posedge clk);
        #1;
        START = 1'b0;
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL accept_busy: BUSY=%b expected 1", BUSY);
        end
    endtask

    // wait for DONE with a cycle budget; cyc counts edges since the call
    task automatic wait_done(output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (BUSY === 1'b1 && DONE === 1'b1) overlap_cnt++;
            if (DONE === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        START = 1'b0;
        SnA   = 1'b0;
        A     = '0;
        B     = '0;
        #2;
        checks++;
        if ({R, CO, OVF, ZERO, BUSY, DONE} !== '0 || dbgState !== IDLE) begin
            errors++;
            $display("FAIL reset_outputs: R=%h CO=%b OVF=%b ZERO=%b BUSY=%b DONE=%b state=%0d expected all 0",
                     R, CO, OVF, ZERO, BUSY, DONE, dbgState);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        logic [W-1:0] va[6] = '{32'h0000000A, 32'hFFFFFFFF, 32'h7FFFFFFF,
                                32'h00000005, 32'h00000003, 32'h80000000};
        logic [W-1:0] vb[6] = '{32'h00000005, 32'h00000001, 32'h00000001,
                                32'h00000005, 32'h00000005, 32'h00000001};
        logic         vs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [W+2:0] ve[6] = '{{32'h0000000F, 1'b0, 1'b0, 1'b0},
                                {32'h00000000, 1'b1, 1'b0, 1'b1},
                                {32'h80000000, 1'b0, 1'b1, 1'b0},
                                {32'h00000000, 1'b1, 1'b0, 1'b1},
                                {32'hFFFFFFFE, 1'b0, 1'b0, 1'b0},
                                {32'h7FFFFFFF, 1'b1, 1'b1, 1'b0}};
        int           cyc;
        bit           seen;
        logic [W+2:0] exp_v;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin
                start_op(va[i], vb[i], vs[i], 1'b1, ve[i]);
            end else begin
                ra = $urandom;
                rb = $urandom;
                rs = 1'($urandom_range(0, 1));
                start_op(ra, rb, rs, 1'b1, model(ra, rb, rs));
            end
            wait_done(cyc, seen);
            checks++;
            if (!seen || cyc != 32) begin
                errors++;
                $display("FAIL arith_latency[%0d]: DONE seen=%b after %0d cycles expected 32", i, seen, cyc);
            end
            exp_v = exp_q.pop_front();
            checks++;
            if ({R, CO, OVF, ZERO} !== exp_v) begin
                errors++;
                $display("FAIL arith_result[%0d]: got R=%h CO=%b OVF=%b ZERO=%b expected %h", i,
                         R, CO, OVF, ZERO, exp_v);
            end
            @(posedge clk);
            #1;
            checks++;
            if (DONE !== 1'b0 || dbgState !== IDLE) begin
                errors++;
                $display("FAIL arith_done_pulse[%0d]: DONE=%b state=%0d expected 0 and IDLE", i, DONE, dbgState);
            end
        end
    endtask

    task automatic test_start_ignored();
        int           cyc;
        bit           seen;
        bit           extra;
        logic [W+2:0] exp_v;
        start_op(32'h12345678, 32'h11111111, 1'b0, 1'b1, {32'h23456789, 1'b0, 1'b0, 1'b0});
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        START = 1'b1;
        A     = 32'hFFFF0000;
        B     = 32'h0000FFFF;
        SnA   = 1'b1;
        @(posedge clk);
        #1;
        START = 1'b0;
        wait_done(cyc, seen);
        checks++;
        if (!seen || cyc + 5 != 32) begin
            errors++;
            $display("FAIL ignore_latency: DONE seen=%b after %0d cycles expected 32", seen, cyc + 5);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if ({R, CO, OVF, ZERO} !== exp_v) begin
            errors++;
            $display("FAIL ignore_result: got R=%h CO=%b OVF=%b ZERO=%b expected %h", R, CO, OVF, ZERO, exp_v);
        end
        extra = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (DONE !== 1'b0 || BUSY !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL ignore_no_restart: activity after completion, expected idle");
        end
    endtask

    task automatic test_back_to_back();
        int           cyc;
        int           gap;
        bit           seen;
        bit           hold_bad;
        logic [W+2:0] e1;
        logic [W+2:0] e2;
        logic [W+2:0] exp_v;
        e1 = {32'h00001234, 1'b0, 1'b0, 1'b0};
        e2 = {32'hFFFFFFF0, 1'b0, 1'b0, 1'b0};
        @(negedge clk);
        A     = 32'h00001000;
        B     = 32'h00000234;
        SnA   = 1'b0;
        START = 1'b1;
        exp_q.push_back(e1);
        @(posedge clk);
        #1;
        wait_done(cyc, seen);
        checks++;
        if (!seen || cyc != 32) begin
            errors++;
            $display("FAIL b2b_first_latency: DONE seen=%b after %0d cycles expected 32", seen, cyc);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if ({R, CO, OVF, ZERO} !== exp_v) begin
            errors++;
            $display("FAIL b2b_first_result: got R=%h CO=%b OVF=%b ZERO=%b expected %h", R, CO, OVF, ZERO, exp_v);
        end
        // START still high through the DONE cycle, with new operands.
        A   = 32'h00000010;
        B   = 32'h00000020;
        SnA = 1'b1;
        exp_q.push_back(e2);
        @(posedge clk);
        #1;
        START = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: BUSY=%b DONE=%b expected 1 and 0", BUSY, DONE);
        end
        gap      = 1;
        hold_bad = 1'b0;
        while (DONE !== 1'b1 && gap < 100) begin
            if (R !== e1[W+2:3]) hold_bad = 1'b1;
            @(posedge clk);
            #1;
            gap++;
            if (BUSY === 1'b1 && DONE === 1'b1) overlap_cnt++;
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL b2b_hold: R changed during RUN, expected %h held", e1[W+2:3]);
        end
        checks++;
        if (gap != 33) begin
            errors++;
            $display("FAIL b2b_gap: second DONE %0d cycles after first, expected 33", gap);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if ({R, CO, OVF, ZERO} !== exp_v) begin
            errors++;
            $display("FAIL b2b_second_result: got R=%h CO=%b OVF=%b ZERO=%b expected %h", R, CO, OVF, ZERO, exp_v);
        end
    endtask

    task automatic test_reset_mid_op();
        int           cyc;
        bit           seen;
        bit           extra;
        logic [W+2:0] exp_v;
        start_op(32'hDEADBEEF, 32'h01010101, 1'b0, 1'b0, '0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({R, CO, OVF, ZERO, BUSY, DONE} !== '0 || dbgState !== IDLE) begin
            errors++;
            $display("FAIL midreset_outputs: R=%h CO=%b OVF=%b ZERO=%b BUSY=%b DONE=%b state=%0d expected all 0",
                     R, CO, OVF, ZERO, BUSY, DONE, dbgState);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (DONE !== 1'b0 || BUSY !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL midreset_no_done: activity after reset, expected idle");
        end
        start_op(32'h00000001, 32'h00000001, 1'b0, 1'b1, {32'h00000002, 1'b0, 1'b0, 1'b0});
        wait_done(cyc, seen);
        checks++;
        if (!seen || cyc != 32) begin
            errors++;
            $display("FAIL midreset_latency: DONE seen=%b after %0d cycles expected 32", seen, cyc);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if ({R, CO, OVF, ZERO} !== exp_v) begin
            errors++;
            $display("FAIL midreset_result: got R=%h CO=%b OVF=%b ZERO=%b expected %h", R, CO, OVF, ZERO, exp_v);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        overlap_cnt = 0;
        test_reset();
        test_arith();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_op();
        checks++;
        if (overlap_cnt !== 0) begin
            errors++;
            $display("FAIL busy_done_overlap: %0d cycles with both high, expected 0", overlap_cnt);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
